data_bus_responder: RTL and testbench
=====================================

Name: data_bus_responder

Overview:
- Memory-mapped data-memory responder on the core's load/store bus; the far end of the `bus_wren`/`bus_rden` strobes the control unit drives.
- Accepts one request at a time and inserts configurable wait states.
- Handles byte, half and word lanes; flags range and alignment errors.
- Backs a synthesizable word array of DEPTH_WORDS entries; returns right-aligned, zero-extended read data (the core performs sign extension).

Parameters:
- ADDR_BASE, 32'h1001_0000, byte address of word 0.
- DEPTH_WORDS, 1024, number of 32-bit words; power of two.
- WAIT_STATES, 1, extra cycles between accept and response (0..15).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- bus_addr  input  32  byte address.
- bus_wdata  input  32  store data, right-aligned.
- bus_size  input  2  00 byte, 01 half, 10 word, 11 reserved (error).
- bus_wren  input  1  store request.
- bus_rden  input  1  load request.
- bus_rdata  output  32  load data, right-aligned, zero-extended; valid only when `bus_ready`.
- bus_ready  output  1  one-cycle response strobe.
- bus_err  output  1  error qualifier, valid only with `bus_ready`.

Behaviour:
- Reset values: `bus_rdata` = 0, `bus_ready` = 0, `bus_err` = 0; FSM in IDLE; wait counter = 0. The memory array is not reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If `bus_wren | bus_rden` is sampled high, capture addr, wdata, size and direction.
  - Set the counter to WAIT_STATES.
  - Go to WAIT, or go directly to RESP when WAIT_STATES = 0.
- WAIT: decrement the counter; go to RESP on the edge where counter = 1.
- RESP:
  - `bus_ready` = 1 for exactly one cycle, then return to IDLE.
  - Back-to-back: a new request can be accepted the cycle after RESP.
- Latency: request accepted in cycle N; `bus_ready` in cycle N+1+WAIT_STATES.
- Initiator rule: the initiator holds the request until `bus_ready`. Inputs are ignored outside IDLE, because the request was captured at accept.
- Write commit:
  - On the clock edge ending RESP, only when `bus_err` = 0 and `rst` = 0.
  - Only selected byte lanes are written: byte lane = `addr[1:0]`, half lanes = `addr[1]`.
  - `bus_wdata` low bits are shifted into the lane; other bytes are unchanged.
- Read data:
  - Array read at accept.
  - Lane extracted and zero-extended, registered into `bus_rdata` on entering RESP.
  - `bus_rdata` returns to 0 in the cycle after RESP.
- Error conditions (`bus_err` = 1 in RESP, `bus_rdata` = 0, no write):
  - Both `bus_wren` and `bus_rden` high at accept.
  - `bus_size` = 11.
  - Address outside [ADDR_BASE, ADDR_BASE+4*DEPTH_WORDS).
  - Misalignment (see optional feature).
- Index = (addr - ADDR_BASE) >> 2, truncated to log2(DEPTH_WORDS) bits after the range check; there is no wrap-around into the array.
- Reset mid-operation: the FSM returns to IDLE and the outputs clear on that edge. A pending store is dropped, including when `rst` coincides with the RESP edge.

Optional Feature:
- Macro: DATA_BUS_RESPONDER_MISALIGN_TRAP_EN.
- Defined:
  - half access with `addr[0]` = 1 is an error;
  - word access with `addr[1:0]` ≠ 0 is an error.
- Undefined:
  - offending low address bits are forced to zero (half ignores bit 0, word ignores bits 1:0);
  - the access proceeds without error.

Decomposition:
- Add to be_pkg:
  - `BUS_SIZE_t` enum (BYTE, HALF, WORD, RSVD);
  - `BUS_RESP_STATE_t` enum (IDLE, WAIT, RESP).
- One sub-module, `bus_lane_align`: combinational write-merge (old word, wdata, size, offset → new word) plus read-extract (word, size, offset → zero-extended data). It is shared later by an MMIO responder.

Test Plan:
- Word write/read, WAIT_STATES=1:
  - SW 32'hDEAD_BEEF to ADDR_BASE+8 → `bus_ready` 2 cycles after accept, `bus_err` = 0.
  - LW of the same address → `bus_rdata` = 32'hDEAD_BEEF.
- Byte/half merge:
  - SB 8'hAA at +9, then SH 16'h1234 at +10, then LW +8 → 32'h1234_AAEF.
  - LB +9 → 32'h0000_00AA.
  - LH +10 → 32'h0000_1234.
- Errors:
  - LW ADDR_BASE+4*DEPTH_WORDS → `bus_err` = 1, `bus_rdata` = 0.
  - `bus_wren` and `bus_rden` both high → `bus_err` = 1, memory unchanged.
  - `bus_size` = 11 → `bus_err` = 1.
- Misalignment, SW 32'h5555_5555 at ADDR_BASE+2:
  - with the macro: `bus_err` = 1, no write;
  - without it: word at ADDR_BASE becomes 32'h5555_5555, `bus_err` = 0.
- Reset mid-op, WAIT_STATES=3:
  - SW 32'hFFFF_FFFF to +0, assert `rst` in the second WAIT cycle.
  - Required: no `bus_ready`; LW +0 returns the prior value; all outputs are 0 the cycle after `rst`.
- Back-to-back, WAIT_STATES=0:
  - Ten alternating SW/LW to ascending addresses with the request held continuously.
  - Required: `bus_ready` every second cycle; all readback values match.

Source files
------------

// File: rtl/be_pkg.sv
// Shared bus-side types for the data-memory responder and its lane helper.
// Holds the access-size and responder-state encodings plus a small helper
// that clears the low address bits an access of a given size ignores.
package be_pkg;

   // Access size as driven on bus_size.
   typedef enum logic [1:0] {
      BYTE = 2'b00,
      HALF = 2'b01,
      WORD = 2'b10,
      RSVD = 2'b11
   } BUS_SIZE_t;

   // Responder handshake states.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } BUS_RESP_STATE_t;

   // Byte offset inside the word that an access of this size really uses.
   function automatic logic [1:0] align_offset(BUS_SIZE_t size, logic [1:0] offset);
      case (size)
         HALF:    return {offset[1], 1'b0};
         WORD:    return 2'b00;
         default: return offset;
      endcase
   endfunction

endpackage

// File: rtl/bus_lane_align.sv
// Byte-lane helper: merges right-aligned store data into an existing word
// and extracts a zero-extended load value from a word. Purely combinational
// so any memory-mapped responder can reuse it.
module bus_lane_align
   import be_pkg::*;
(
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   input  BUS_SIZE_t   size,
   input  logic [1:0]  offset,
   output logic [31:0] new_word,
   output logic [31:0] rd_data
);

   // Merge store lanes into the old word and pull out the addressed load lanes.
   always_comb begin
      // NOTE: every output gets a default first so no path through the case leaves it unassigned, which would infer a latch.
      new_word = word;
      rd_data  = '0;
      case (size)
         BYTE: begin
            new_word[{offset, 3'b000} +: 8] = wdata[7:0];
            rd_data[7:0]                    = word[{offset, 3'b000} +: 8];
         end
         HALF: begin
            new_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            rd_data[15:0]                        = word[{offset[1], 4'b0000} +: 16];
         end
         WORD: begin
            new_word = wdata;
            rd_data  = word;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/data_bus_responder.sv
// Data-memory responder on the core load/store bus. Accepts one request at a
// time, waits WAIT_STATES cycles, then pulses bus_ready for one cycle with
// right-aligned zero-extended load data or an error flag.
// Optional build macro DATA_BUS_RESPONDER_MISALIGN_TRAP_EN: misaligned half
// and word accesses become errors instead of having their low address bits
// silently cleared.
module data_bus_responder
   import be_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE   = 32'h1001_0000,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] bus_addr,
   input  logic [31:0] bus_wdata,
   input  logic [1:0]  bus_size,
   input  logic        bus_wren,
   input  logic        bus_rden,
   output logic [31:0] bus_rdata,
   output logic        bus_ready,
   output logic        bus_err
);

   localparam int unsigned IDX_W   = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN    = 32'(DEPTH_WORDS * 4);
   localparam logic [3:0]  WS_INIT = 4'(WAIT_STATES);

   BUS_RESP_STATE_t state, state_next;
   logic [3:0]      cnt;
   logic [31:0]     mem [DEPTH_WORDS];

   // Request captured at accept; the initiator's held inputs are not used afterwards.
   logic [IDX_W-1:0] cap_idx;
   logic [1:0]       cap_off;
   BUS_SIZE_t        cap_size;
   logic [31:0]      cap_wdata;
   logic [31:0]      cap_word;
   logic             cap_wr;
   logic             cap_err;

   // Live decode of the bus inputs, meaningful only while IDLE.
   BUS_SIZE_t        live_size;
   logic [31:0]      rel;
   logic [IDX_W-1:0] live_idx;
   logic [1:0]       live_off;
   logic             misalign;
   logic             live_err;
   logic             accept;

   assign live_size = BUS_SIZE_t'(bus_size);
   assign rel       = bus_addr - ADDR_BASE;
   assign live_idx  = rel[IDX_W+1:2];
   assign live_off  = align_offset(live_size, bus_addr[1:0]);

`ifdef DATA_BUS_RESPONDER_MISALIGN_TRAP_EN
   assign misalign = ((live_size == HALF) && bus_addr[0]) ||
                     ((live_size == WORD) && (bus_addr[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   // Range is checked on the full address before the index is truncated, so nothing wraps into the array.
   assign live_err = (bus_wren & bus_rden) | (live_size == RSVD) |
                     (bus_addr < ADDR_BASE) | (rel >= SPAN) | misalign;
   assign accept   = (state == IDLE) && (bus_wren || bus_rden);

   // With zero wait states RESP is entered straight from IDLE, so the lane
   // logic must see the live request then and the captured one otherwise.
   logic        use_live;
   logic        resp_enter;
   logic [31:0] sel_word;
   logic [31:0] sel_wdata;
   BUS_SIZE_t   sel_size;
   logic [1:0]  sel_off;
   logic        sel_wr;
   logic        sel_err;
   logic [31:0] new_word;
   logic [31:0] rd_data;

   assign use_live   = (state == IDLE);
   assign sel_word   = use_live ? mem[live_idx] : cap_word;
   assign sel_wdata  = use_live ? bus_wdata     : cap_wdata;
   assign sel_size   = use_live ? live_size     : cap_size;
   assign sel_off    = use_live ? live_off      : cap_off;
   assign sel_wr     = use_live ? bus_wren      : cap_wr;
   assign sel_err    = use_live ? live_err      : cap_err;
   assign resp_enter = (state != RESP) && (state_next == RESP);

   bus_lane_align u_lane (
      .word     (sel_word),
      .wdata    (sel_wdata),
      .size     (sel_size),
      .offset   (sel_off),
      .new_word (new_word),
      .rd_data  (rd_data)
   );

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic: accept in IDLE, count down in WAIT, single-cycle RESP.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = (WAIT_STATES == 0) ? RESP : WAIT;
         WAIT:    if (cnt == 4'd1) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Wait counter and registered response outputs; outputs are non-zero only during RESP.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         bus_ready <= 1'b0;
         bus_err   <= 1'b0;
         bus_rdata <= '0;
      end else begin
         bus_ready <= resp_enter;
         bus_err   <= resp_enter && sel_err;
         bus_rdata <= (resp_enter && !sel_err && !sel_wr) ? rd_data : '0;
         if (accept)              cnt <= WS_INIT;
         else if (state == WAIT)  cnt <= cnt - 4'd1;
      end
   end

   // Capture the request and the addressed array word at accept.
   always_ff @(posedge clk) begin
      if (accept) begin
         cap_idx   <= live_idx;
         cap_off   <= live_off;
         cap_size  <= live_size;
         cap_wdata <= bus_wdata;
         cap_word  <= mem[live_idx];
         cap_wr    <= bus_wren;
         cap_err   <= live_err;
      end
   end

   // Commit the merged word on the edge that ends RESP; a coincident reset drops it.
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset branch so it maps onto plain RAM; contents are undefined until written.
      if (!rst && (state == RESP) && cap_wr && !cap_err) mem[cap_idx] <= new_word;
   end

endmodule

// File: tb/tb_data_bus_responder.sv
// Self-checking bench for data_bus_responder. Three instances run with
// WAIT_STATES = 1, 3 and 0; a byte-addressed reference memory per instance
// predicts load data, error flags and latency.
module tb_data_bus_responder;

   localparam logic [31:0] BASE  = 32'h1001_0000;
   localparam int          DEPTH = 1024;
   localparam int          NB    = 4 * DEPTH;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr  [3];
   logic [31:0] wdata [3];
   logic [1:0]  size  [3];
   logic        wren  [3];
   logic        rden  [3];
   logic [31:0] rdata [3];
   logic        ready [3];
   logic        err   [3];

   logic [7:0]  mdl [3][NB];
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   data_bus_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) u_dut_ws1 (
      .clk(clk), .rst(rst), .bus_addr(addr[0]), .bus_wdata(wdata[0]), .bus_size(size[0]),
      .bus_wren(wren[0]), .bus_rden(rden[0]), .bus_rdata(rdata[0]), .bus_ready(ready[0]), .bus_err(err[0]));

   data_bus_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u_dut_ws3 (
      .clk(clk), .rst(rst), .bus_addr(addr[1]), .bus_wdata(wdata[1]), .bus_size(size[1]),
      .bus_wren(wren[1]), .bus_rden(rden[1]), .bus_rdata(rdata[1]), .bus_ready(ready[1]), .bus_err(err[1]));

   data_bus_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut_ws0 (
      .clk(clk), .rst(rst), .bus_addr(addr[2]), .bus_wdata(wdata[2]), .bus_size(size[2]),
      .bus_wren(wren[2]), .bus_rden(rden[2]), .bus_rdata(rdata[2]), .bus_ready(ready[2]), .bus_err(err[2]));

   function automatic int ws_of(int d);
      case (d)
         0:       return 1;
         1:       return 3;
         default: return 0;
      endcase
   endfunction

   // Reference rules: which requests must be refused.
   function automatic bit model_err(bit w, bit r, logic [1:0] sz, logic [31:0] a);
      if (w && r) return 1'b1;
      if (sz == 2'b11) return 1'b1;
      if (a < BASE || a >= BASE + NB) return 1'b1;
`ifdef DATA_BUS_RESPONDER_MISALIGN_TRAP_EN
      if (sz == 2'b01 && a[0]) return 1'b1;
      if (sz == 2'b10 && a[1:0] != 2'b00) return 1'b1;
`endif
      return 1'b0;
   endfunction

   // First byte touched: access is naturally aligned down to its own size.
   function automatic int first_byte(logic [1:0] sz, logic [31:0] a);
      int n;
      logic [31:0] off;
      n   = 1 << sz;
      off = a - BASE;
      return int'(off) & ~(n - 1);
   endfunction

   function automatic logic [31:0] model_load(int d, logic [1:0] sz, logic [31:0] a);
      logic [31:0] v;
      int e;
      v = '0;
      e = first_byte(sz, a);
      for (int k = 0; k < (1 << sz); k++) v[8*k +: 8] = mdl[d][e + k];
      return v;
   endfunction

   task automatic model_store(int d, logic [1:0] sz, logic [31:0] a, logic [31:0] wd);
      int e;
      e = first_byte(sz, a);
      for (int k = 0; k < (1 << sz); k++) mdl[d][e + k] = wd[8*k +: 8];
   endtask

   task automatic idle_bus(int d);
      wren[d] = 1'b0;
      rden[d] = 1'b0;
   endtask

   // One request: drive and hold, wait for bus_ready, check latency/err/data,
   // then check the outputs clear one cycle later. Inputs stay driven on
   // return so a following call continues back-to-back.
   task automatic do_txn(input int d, input bit w, input bit r, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd, input string tag,
                         output logic [31:0] got, output logic got_err);
      bit          exp_err;
      logic [31:0] exp_data;
      bit          seen;
      int          lat;
      exp_err  = model_err(w, r, sz, a);
      exp_data = (!exp_err && r) ? model_load(d, sz, a) : 32'h0;
      wren[d] = w; rden[d] = r; size[d] = sz; addr[d] = a; wdata[d] = wd;
      seen = 1'b0;
      lat  = 0;
      for (int c = 1; c <= 40 && !seen; c++) begin
         @(posedge clk); #1;
         lat = c;
         if (ready[d] === 1'b1) seen = 1'b1;
      end
      got     = rdata[d];
      got_err = err[d];
      n_tests++;
      if (!seen || lat != ws_of(d) + 1) begin
         n_fail++;
         $display("FAIL %s latency: seen=%0d cycles=%0d expected %0d", tag, seen, lat, ws_of(d) + 1);
      end
      n_tests++;
      if (got_err !== exp_err) begin
         n_fail++;
         $display("FAIL %s err: got %b expected %b", tag, got_err, exp_err);
      end
      if (r || exp_err) begin
         n_tests++;
         if (got !== exp_data) begin
            n_fail++;
            $display("FAIL %s rdata: got %h expected %h", tag, got, exp_data);
         end
      end
      if (!exp_err && w) model_store(d, sz, a, wd);
      @(posedge clk); #1;
      n_tests++;
      if ({ready[d], err[d], rdata[d]} !== 34'h0) begin
         n_fail++;
         $display("FAIL %s after-resp: got ready=%b err=%b rdata=%h expected all 0", tag, ready[d], err[d], rdata[d]);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int d = 0; d < 3; d++) begin
         idle_bus(d);
         addr[d] = '0; wdata[d] = '0; size[d] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         n_tests++;
         if ({ready[d], err[d], rdata[d]} !== 34'h0) begin
            n_fail++;
            $display("FAIL reset dut%0d: got ready=%b err=%b rdata=%h expected all 0", d, ready[d], err[d], rdata[d]);
         end
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_word();
      logic [31:0] g; logic ge;
      do_txn(0, 1, 0, 2'b10, BASE + 8, 32'hDEAD_BEEF, "sw_word", g, ge);
      do_txn(0, 0, 1, 2'b10, BASE + 8, 32'h0, "lw_word", g, ge);
      idle_bus(0);
      n_tests++;
      if (g !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL word_readback: got %h expected %h", g, 32'hDEAD_BEEF);
      end
   endtask

   task automatic test_merge();
      logic [31:0] g; logic ge;
      do_txn(0, 1, 0, 2'b00, BASE + 9,  32'h0000_00AA, "sb", g, ge);
      do_txn(0, 1, 0, 2'b01, BASE + 10, 32'h0000_1234, "sh", g, ge);
      do_txn(0, 0, 1, 2'b10, BASE + 8,  32'h0, "lw_merged", g, ge);
      n_tests++;
      if (g !== 32'h1234_AAEF) begin
         n_fail++;
         $display("FAIL merge_word: got %h expected %h", g, 32'h1234_AAEF);
      end
      do_txn(0, 0, 1, 2'b00, BASE + 9, 32'h0, "lb", g, ge);
      n_tests++;
      if (g !== 32'h0000_00AA) begin
         n_fail++;
         $display("FAIL merge_lb: got %h expected %h", g, 32'h0000_00AA);
      end
      do_txn(0, 0, 1, 2'b01, BASE + 10, 32'h0, "lh", g, ge);
      idle_bus(0);
      n_tests++;
      if (g !== 32'h0000_1234) begin
         n_fail++;
         $display("FAIL merge_lh: got %h expected %h", g, 32'h0000_1234);
      end
   endtask

   task automatic test_errors();
      logic [31:0] g; logic ge;
      do_txn(0, 0, 1, 2'b10, BASE + NB, 32'h0, "lw_past_end", g, ge);
      n_tests++;
      if (ge !== 1'b1 || g !== 32'h0) begin
         n_fail++;
         $display("FAIL past_end: got err=%b rdata=%h expected err=1 rdata=0", ge, g);
      end
      do_txn(0, 0, 1, 2'b10, BASE - 4, 32'h0, "lw_below_base", g, ge);
      do_txn(0, 1, 1, 2'b10, BASE + 8, 32'h1111_2222, "both_strobes", g, ge);
      n_tests++;
      if (ge !== 1'b1) begin
         n_fail++;
         $display("FAIL both_strobes_err: got %b expected 1", ge);
      end
      do_txn(0, 0, 1, 2'b10, BASE + 8, 32'h0, "lw_after_both", g, ge);
      n_tests++;
      if (g !== 32'h1234_AAEF) begin
         n_fail++;
         $display("FAIL both_strobes_nowrite: got %h expected %h", g, 32'h1234_AAEF);
      end
      do_txn(0, 1, 0, 2'b11, BASE + 8, 32'h3333_4444, "size_rsvd", g, ge);
      n_tests++;
      if (ge !== 1'b1) begin
         n_fail++;
         $display("FAIL size_rsvd_err: got %b expected 1", ge);
      end
      do_txn(0, 1, 0, 2'b10, BASE + NB - 4, 32'hA5A5_5A5A, "sw_last", g, ge);
      do_txn(0, 0, 1, 2'b10, BASE + NB - 4, 32'h0, "lw_last", g, ge);
      idle_bus(0);
   endtask

   task automatic test_misalign();
      logic [31:0] g; logic ge;
      logic [31:0] exp_word;
      logic        exp_e;
`ifdef DATA_BUS_RESPONDER_MISALIGN_TRAP_EN
      exp_word = 32'h0;
      exp_e    = 1'b1;
`else
      exp_word = 32'h5555_5555;
      exp_e    = 1'b0;
`endif
      do_txn(0, 1, 0, 2'b10, BASE, 32'h0, "sw_clear", g, ge);
      do_txn(0, 1, 0, 2'b10, BASE + 2, 32'h5555_5555, "sw_misaligned", g, ge);
      n_tests++;
      if (ge !== exp_e) begin
         n_fail++;
         $display("FAIL misalign_err: got %b expected %b", ge, exp_e);
      end
      do_txn(0, 0, 1, 2'b10, BASE, 32'h0, "lw_misalign_chk", g, ge);
      idle_bus(0);
      n_tests++;
      if (g !== exp_word) begin
         n_fail++;
         $display("FAIL misalign_word: got %h expected %h", g, exp_word);
      end
   endtask

   task automatic test_reset_mid_op();
      logic [31:0] g; logic ge;
      // Reset in the second WAIT cycle of a WAIT_STATES=3 store.
      do_txn(1, 1, 0, 2'b10, BASE, 32'h0BAD_F00D, "sw_prior", g, ge);
      wren[1] = 1'b1; rden[1] = 1'b0; size[1] = 2'b10; addr[1] = BASE; wdata[1] = 32'hFFFF_FFFF;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         n_tests++;
         if (ready[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_wait%0d ready: got %b expected 0", c, ready[1]);
         end
      end
      rst = 1'b1;
      idle_bus(1);
      @(posedge clk); #1;
      n_tests++;
      if ({ready[1], err[1], rdata[1]} !== 34'h0) begin
         n_fail++;
         $display("FAIL midop_outputs: got ready=%b err=%b rdata=%h expected all 0", ready[1], err[1], rdata[1]);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if (ready[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL midop_no_ready: got %b expected 0", ready[1]);
      end
      do_txn(1, 0, 1, 2'b10, BASE, 32'h0, "lw_after_midop", g, ge);
      idle_bus(1);
      n_tests++;
      if (g !== 32'h0BAD_F00D) begin
         n_fail++;
         $display("FAIL midop_dropped: got %h expected %h", g, 32'h0BAD_F00D);
      end
      // Reset coinciding with the edge that ends RESP must drop the store.
      do_txn(2, 1, 0, 2'b10, BASE + 32'h20, 32'h1111_2222, "sw_prior_ws0", g, ge);
      wren[2] = 1'b1; rden[2] = 1'b0; size[2] = 2'b10; addr[2] = BASE + 32'h20; wdata[2] = 32'hCAFE_0000;
      @(posedge clk); #1;
      n_tests++;
      if (ready[2] !== 1'b1) begin
         n_fail++;
         $display("FAIL resp_rst ready: got %b expected 1", ready[2]);
      end
      rst = 1'b1;
      idle_bus(2);
      @(posedge clk); #1;
      rst = 1'b0;
      n_tests++;
      if ({ready[2], err[2], rdata[2]} !== 34'h0) begin
         n_fail++;
         $display("FAIL resp_rst outputs: got ready=%b err=%b rdata=%h expected all 0", ready[2], err[2], rdata[2]);
      end
      do_txn(2, 0, 1, 2'b10, BASE + 32'h20, 32'h0, "lw_after_resp_rst", g, ge);
      idle_bus(2);
      n_tests++;
      if (g !== 32'h1111_2222) begin
         n_fail++;
         $display("FAIL resp_rst_dropped: got %h expected %h", g, 32'h1111_2222);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] g; logic ge;
      logic [31:0] a;
      logic [31:0] v;
      for (int i = 0; i < 5; i++) begin
         a = BASE + 32'h100 + 32'(4 * i);
         v = $urandom;
         do_txn(2, 1, 0, 2'b10, a, v, "b2b_sw", g, ge);
         do_txn(2, 0, 1, 2'b10, a, 32'h0, "b2b_lw", g, ge);
         n_tests++;
         if (g !== v) begin
            n_fail++;
            $display("FAIL b2b_readback%0d: got %h expected %h", i, g, v);
         end
      end
      idle_bus(2);
      @(posedge clk); #1;
   endtask

   task automatic test_random(int d);
      logic [31:0] g; logic ge;
      logic [31:0] a;
      bit          w, r;
      int          sel;
      for (int k = 0; k < 16; k++) do_txn(d, 1, 0, 2'b10, BASE + 32'(4 * k), $urandom, "rnd_init", g, ge);
      for (int n = 0; n < 150; n++) begin
         a   = BASE - 8 + 32'($urandom_range(0, 79));
         sel = $urandom_range(0, 7);
         w   = (sel < 4) || (sel == 7);
         r   = (sel >= 4);
         do_txn(d, w, r, 2'($urandom_range(0, 3)), a, $urandom, "rnd", g, ge);
      end
      idle_bus(d);
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_word();
      test_merge();
      test_errors();
      test_misalign();
      test_reset_mid_op();
      test_back_to_back();
      test_random(0);
      test_random(2);
      test_random(1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
